// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Instruction fetch / PC stage: req/ack fetch, next-PC select,
//                link address and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        bne,
    input  logic        jr,
    input  logic        jal,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic        fetch_err,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Last REQ cycle index in which an ack is still accepted.
    localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_fetch_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;
    logic        w_br_taken;
    logic [31:0] w_next_pc;
    logic        w_nonseq;

    // jal only matters to the register file; it needs no decode here.
    wire w_unused_jal = jal;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_offset;
    assign w_j_target  = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_jr_target = {rs_data[31:2], 2'b00};
    assign w_br_taken  = (Branch & zero) | (bne & ~zero);

    always_comb begin
        w_next_pc = w_pc_plus4;
        w_nonseq  = 1'b0;
        if (jr) begin
            w_next_pc = w_jr_target;
            w_nonseq  = 1'b1;
        end else if (Jump) begin
            w_next_pc = w_j_target;
            w_nonseq  = 1'b1;
        end else if (w_br_taken) begin
            w_next_pc = w_br_target;
            w_nonseq  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_wait_cnt    <= 8'd0;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_retired     <= 32'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_REQ;
                    r_wait_cnt <= 8'd0;
                    r_imem_req <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_state       <= ST_EXEC;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_state     <= ST_ERR;
                        r_imem_req  <= 1'b0;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_retired     <= r_retired + 32'd1;
                        r_state       <= ST_REQ;
                        r_wait_cnt    <= 8'd0;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    // ST_ERR is terminal until reset.
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign link_addr   = w_pc_plus4;
    assign redirect    = r_instr_valid & ~stall & w_nonseq;
    assign fetch_err   = r_fetch_err;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Self-checking bench for fetch_pc_unit with an address scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 4;

    // Control vector bit order: {jr, jal, Jump, Branch, bne}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_BNE  = 5'b00001;
    localparam logic [4:0] C_BR   = 5'b00010;
    localparam logic [4:0] C_J    = 5'b00100;
    localparam logic [4:0] C_JALR = 5'b11100;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, instr, rs_data, pc, link_addr, retired;
    logic [5:0]  opcode;
    logic        instr_valid, redirect, fetch_err, stall, zero;
    logic        Jump, Branch, bne, jr, jal;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_retired = 0;
    logic [31:0] exp_addr[$];

    fetch_pc_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .Jump(Jump), .Branch(Branch), .bne(bne), .jr(jr), .jal(jal),
        .zero(zero), .rs_data(rs_data), .stall(stall),
        .pc(pc), .link_addr(link_addr), .redirect(redirect),
        .fetch_err(fetch_err), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic [4:0] ctl, input logic z, input logic [31:0] rs);
        {jr, jal, Jump, Branch, bne} = ctl;
        zero    = z;
        rs_data = rs;
    endtask

    // Reference next-PC model, written from the architectural definition.
    task automatic model_next(input logic [31:0] cur, input logic [31:0] word,
                              input logic [4:0] ctl, input logic z, input logic [31:0] rs,
                              output logic [31:0] nxt, output logic redir);
        logic signed [31:0] imm;
        logic [31:0] seq;
        imm = 32'(signed'(word[15:0]));
        seq = cur + 32'd4;
        if (ctl[4]) begin
            nxt = rs & 32'hFFFF_FFFC; redir = 1'b1;
        end else if (ctl[2]) begin
            nxt = (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4); redir = 1'b1;
        end else if ((ctl[1] && z) || (ctl[0] && !z)) begin
            nxt = seq + 32'(imm * 4); redir = 1'b1;
        end else begin
            nxt = seq; redir = 1'b0;
        end
    endtask

    task automatic wait_req();
        int waited;
        waited = 0;
        while (!imem_req && waited < 8) begin
            tick();
            waited++;
        end
        check_eq("req_seen", 32'(imem_req), 32'd1);
    endtask

    task automatic pop_addr(output logic [31:0] a);
        if (exp_addr.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            a = 32'hDEAD_BEEF;
        end else begin
            a = exp_addr.pop_front();
        end
        check_eq("imem_addr", imem_addr, a);
    endtask

    task automatic fetch(input logic [31:0] word, input int ack_delay);
        repeat (ack_delay) tick();
        imem_ack = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        check_eq("exec_valid", 32'(instr_valid), 32'd1);
        check_eq("instr", instr, word);
        check_eq("opcode", 32'(opcode), 32'(word[31:26]));
    endtask

    task automatic run_instr(input logic [31:0] word, input logic [4:0] ctl, input logic z,
                             input logic [31:0] rs, input int ack_delay, input int stall_cycles);
        logic [31:0] cur, nxt;
        logic redir;
        set_ctl(C_NONE, 1'b0, 32'd0);
        wait_req();
        pop_addr(cur);
        fetch(word, ack_delay);
        set_ctl(ctl, z, rs);
        for (int s = 0; s < stall_cycles; s++) begin
            stall = 1'b1;
            imem_ack = 1'b1;
            #1;
            check_eq("stall_redirect", 32'(redirect), 32'd0);
            tick();
            imem_ack = 1'b0;
            check_eq("stall_pc", pc, cur);
            check_eq("stall_instr", instr, word);
            check_eq("stall_retired", retired, 32'(exp_retired));
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        #1;
        model_next(cur, word, ctl, z, rs, nxt, redir);
        check_eq("redirect", 32'(redirect), 32'(redir));
        check_eq("link_addr", link_addr, cur + 32'd4);
        exp_addr.push_back(nxt);
        exp_retired++;
        tick();
        set_ctl(C_NONE, 1'b0, 32'd0);
        check_eq("retired", retired, 32'(exp_retired));
        check_eq("valid_low_in_req", 32'(instr_valid), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_err", 32'(fetch_err), 32'd0);
        check_eq("rst_redirect", 32'(redirect), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_opcode", 32'(opcode), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_link", link_addr, RESET_PC + 32'd4);
    endtask

    task automatic restart_model();
        exp_addr.delete();
        exp_addr.push_back(RESET_PC);
        exp_retired = 0;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        stall = 1'b0;
        set_ctl(C_NONE, 1'b0, 32'd0);
        #2;
        check_reset_outputs();
        tick();
        tick();
        rst = 1'b0;
        restart_model();
        check_eq("boot_no_req", 32'(imem_req), 32'd0);

        // Sequential flow: 0, 4, 8 then 12.
        run_instr(32'h2000_0001, C_NONE, 1'b0, 32'd0, 0, 0);
        run_instr(32'h2000_0002, C_NONE, 1'b0, 32'd0, 0, 0);
        run_instr(32'h2000_0003, C_NONE, 1'b0, 32'd0, 0, 0);
        check_eq("retired_after_3", retired, 32'd3);

        run_instr(32'h0800_0040, C_J,   1'b0, 32'd0, 0, 0);   // 12    -> 0x100
        run_instr(32'h1000_FFFE, C_BR,  1'b1, 32'd0, 0, 0);   // 0x100 -> 0x0FC
        run_instr(32'h1000_FFFE, C_BR,  1'b0, 32'd0, 0, 0);   // 0x0FC -> 0x100
        run_instr(32'h1000_FFFE, C_BR,  1'b0, 32'd0, 0, 0);   // 0x100 -> 0x104
        run_instr(32'h0800_0010, C_J,   1'b0, 32'd0, 0, 0);   // 0x104 -> 0x040
        run_instr(32'h0800_0100, C_J,   1'b0, 32'd0, 0, 0);   // 0x040 -> 0x400
        run_instr(32'h0800_0010, C_J,   1'b0, 32'd0, 0, 0);   // 0x400 -> 0x040
        run_instr(32'h0800_0100, C_JALR, 1'b0, 32'h0000_2003, 0, 0); // -> 0x2000
        run_instr(32'h0800_0008, C_J,   1'b0, 32'd0, 0, 0);   // 0x2000 -> 0x20
        run_instr(32'h1400_0003, C_BNE, 1'b0, 32'd0, 0, 0);   // 0x20  -> 0x30
        run_instr(32'h0800_0008, C_J,   1'b0, 32'd0, 0, 0);   // 0x30  -> 0x20
        run_instr(32'h1400_0003, C_BNE, 1'b1, 32'd0, 0, 0);   // 0x20  -> 0x24
        run_instr(32'h2000_0024, C_NONE, 1'b0, 32'd0, 0, 3);  // stalled, -> 0x28
        run_instr(32'h2000_0028, C_NONE, 1'b0, 32'd0, MAX_WAIT - 1, 0); // late ack

        // Fetch at 0x2C never acknowledged.
        wait_req();
        pop_addr(a);
        repeat (MAX_WAIT - 1) tick();
        check_eq("timeout_req_still", 32'(imem_req), 32'd1);
        check_eq("timeout_no_err_yet", 32'(fetch_err), 32'd0);
        tick();
        check_eq("err_set", 32'(fetch_err), 32'd1);
        check_eq("err_req_low", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        check_eq("err_sticky", 32'(fetch_err), 32'd1);
        check_eq("err_req_still_low", 32'(imem_req), 32'd0);
        check_eq("err_valid_low", 32'(instr_valid), 32'd0);
        check_eq("err_pc_hold", pc, 32'h0000_002C);

        rst = 1'b1;
        #1;
        check_reset_outputs();
        tick();
        rst = 1'b0;
        restart_model();

        // Reach 0x80, stall there, then reset asynchronously mid-cycle.
        run_instr(32'h0800_0020, C_J, 1'b0, 32'd0, 0, 0);
        wait_req();
        pop_addr(a);
        fetch(32'h2000_0080, 0);
        stall = 1'b1;
        tick();
        tick();
        check_eq("pre_rst_pc", pc, 32'h0000_0080);
        check_eq("pre_rst_retired", retired, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_pc", pc, RESET_PC);
        check_eq("async_rst_retired", retired, 32'd0);
        check_eq("async_rst_valid", 32'(instr_valid), 32'd0);
        stall = 1'b0;
        tick();
        rst = 1'b0;
        restart_model();
        check_eq("post_rst_boot", 32'(imem_req), 32'd0);
        tick();
        check_eq("post_rst_req", 32'(imem_req), 32'd1);
        pop_addr(a);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
